spi_xfer_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `spi_master` instance between `NUM_REQ` independent requesters. It accepts one transfer request at a time, launches it on the master with the requested slave select, waits for completion, and returns the received word to the winning requester. The block sits between the on-chip clients (register bridge, DMA, sensor pollers) and the single SPI master.

---
 rtl/spi_xfer_arbiter_if.sv | 32 +++
 rtl/spi_xfer_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_spi_xfer_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_arbiter_if.sv
// Request/response and SPI-master bundle for spi_xfer_arbiter.
// The arbiter connects through modport master; requesters and the SPI master side use modport slave.
interface spi_xfer_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLAVES = 2,
    parameter int SEL_W      = 2
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*SEL_W-1:0]      req_slave;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_err;
    logic                          m_start;
    logic [DATA_WIDTH-1:0]         m_tx_data;
    logic [NUM_SLAVES-1:0]         m_ss_sel;
    logic                          m_busy;
    logic                          m_done;
    logic [DATA_WIDTH-1:0]         m_rx_data;
    logic                          active;

    modport master (
        input  req, req_slave, req_data, m_busy, m_done, m_rx_data,
        output done, rsp_data, rsp_err, m_start, m_tx_data, m_ss_sel, active
    );

    modport slave (
        output req, req_slave, req_data, m_busy, m_done, m_rx_data,
        input  done, rsp_data, rsp_err, m_start, m_tx_data, m_ss_sel, active
    );
endinterface

// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master between NUM_REQ requesters.
// Optional watchdog on the master completion is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_xfer_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_SLAVES     = 2,
    parameter int SEL_W          = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_xfer_arbiter_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    // Returns {found, index} of the first set bit at or above ptr, wrapping.
    // Scanning offsets downward lets the smallest offset overwrite the rest.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req_v,
                                               input logic [IDX_W-1:0]   ptr);
        logic             found;
        logic [IDX_W-1:0] idx;
        int               cand;
        found = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (req_v[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1'b1) << idx;
    endfunction

    function automatic logic [NUM_SLAVES-1:0] slave_onehot(input logic [SEL_W-1:0] sel);
        return NUM_SLAVES'(1'b1) << sel;
    endfunction

    state_t                  state_r, state_nxt_s;
    logic [IDX_W-1:0]        win_r, win_nxt_s;
    logic [IDX_W-1:0]        rr_ptr_r, rr_ptr_nxt_s;
    logic [NUM_REQ-1:0]      done_r, done_nxt_s;
    logic [DATA_WIDTH-1:0]   rsp_data_r, rsp_data_nxt_s;
    logic                    rsp_err_r, rsp_err_nxt_s;
    logic                    m_start_r, m_start_nxt_s;
    logic [DATA_WIDTH-1:0]   m_tx_data_r, m_tx_data_nxt_s;
    logic [NUM_SLAVES-1:0]   m_ss_sel_r, m_ss_sel_nxt_s;
    logic                    active_r;

    logic [IDX_W:0]          pick_s;
    logic                    grant_vld_s;
    logic [IDX_W-1:0]        grant_idx_s;
    logic [SEL_W-1:0]        grant_sel_s;
    logic [DATA_WIDTH-1:0]   grant_data_s;
    logic                    cfg_unused_s;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
    logic [CNT_W-1:0]        cnt_inc_s;
    assign cnt_inc_s = cnt_r + CNT_W'(1);
`endif

    // m_busy carries no decision; it is tied into a sink alongside the
    // watchdog limit, which the default build does not use.
    assign cfg_unused_s = bus.m_busy | (TIMEOUT_CYCLES < 2);

    assign pick_s       = rr_pick(bus.req, rr_ptr_r);
    assign grant_vld_s  = pick_s[IDX_W];
    assign grant_idx_s  = pick_s[IDX_W-1:0];
    assign grant_sel_s  = bus.req_slave[grant_idx_s*SEL_W +: SEL_W];
    assign grant_data_s = bus.req_data[grant_idx_s*DATA_WIDTH +: DATA_WIDTH];

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that every port comes straight from a flop.
    always_comb begin
        state_nxt_s     = state_r;
        win_nxt_s       = win_r;
        rr_ptr_nxt_s    = rr_ptr_r;
        done_nxt_s      = {NUM_REQ{1'b0}};
        rsp_data_nxt_s  = rsp_data_r;
        rsp_err_nxt_s   = rsp_err_r;
        m_start_nxt_s   = 1'b0;
        m_tx_data_nxt_s = m_tx_data_r;
        m_ss_sel_nxt_s  = m_ss_sel_r;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_nxt_s       = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (grant_vld_s) begin
                    win_nxt_s = grant_idx_s;
                    if (int'(grant_sel_s) >= NUM_SLAVES) begin
                        state_nxt_s    = ST_RESP;
                        done_nxt_s     = req_onehot(grant_idx_s);
                        rsp_data_nxt_s = {DATA_WIDTH{1'b0}};
                        rsp_err_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s     = ST_LAUNCH;
                        m_start_nxt_s   = 1'b1;
                        m_tx_data_nxt_s = grant_data_s;
                        m_ss_sel_nxt_s  = slave_onehot(grant_sel_s);
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_nxt_s = ST_WAIT_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_nxt_s   = {CNT_W{1'b0}};
`endif
            end
            ST_WAIT_DONE: begin
                if (bus.m_done) begin
                    state_nxt_s    = ST_RESP;
                    done_nxt_s     = req_onehot(win_r);
                    rsp_data_nxt_s = bus.m_rx_data;
                    rsp_err_nxt_s  = 1'b0;
                end else begin
`ifdef SPI_ARB_TIMEOUT_EN
                    // Completion has priority; the watchdog only fires without m_done.
                    cnt_nxt_s = cnt_inc_s;
                    if (cnt_inc_s == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_nxt_s    = ST_RESP;
                        done_nxt_s     = req_onehot(win_r);
                        rsp_data_nxt_s = {DATA_WIDTH{1'b0}};
                        rsp_err_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT_DONE;
                    end
`else
                    state_nxt_s = ST_WAIT_DONE;
`endif
                end
            end
            ST_RESP: begin
                state_nxt_s    = ST_IDLE;
                m_ss_sel_nxt_s = {NUM_SLAVES{1'b0}};
                rr_ptr_nxt_s   = (win_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                                : win_r + IDX_W'(1);
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, arbitration pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            win_r       <= {IDX_W{1'b0}};
            rr_ptr_r    <= {IDX_W{1'b0}};
            done_r      <= {NUM_REQ{1'b0}};
            rsp_data_r  <= {DATA_WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
            m_start_r   <= 1'b0;
            m_tx_data_r <= {DATA_WIDTH{1'b0}};
            m_ss_sel_r  <= {NUM_SLAVES{1'b0}};
            active_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            win_r       <= win_nxt_s;
            rr_ptr_r    <= rr_ptr_nxt_s;
            done_r      <= done_nxt_s;
            rsp_data_r  <= rsp_data_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            m_start_r   <= m_start_nxt_s;
            m_tx_data_r <= m_tx_data_nxt_s;
            m_ss_sel_r  <= m_ss_sel_nxt_s;
            active_r    <= (state_nxt_s != ST_IDLE);
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog counter for the wait on master completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end
`endif

    assign bus.done      = done_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.m_start   = m_start_r;
    assign bus.m_tx_data = m_tx_data_r;
    assign bus.m_ss_sel  = m_ss_sel_r;
    assign bus.active    = active_r;
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Self-checking bench for spi_xfer_arbiter: directed cases plus randomized
// transfers checked against a round-robin reference model.
module tb_spi_xfer_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;
    localparam int NS = 2;
    localparam int SW = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_xfer_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_W(SW)) bus ();

    spi_xfer_arbiter #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SEL_W(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int model_pick(input logic [NR-1:0] rq, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (rq[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return 0;
    endfunction

    // One transfer starting from an IDLE cycle (called at a negedge).
    // dly < 0 means the master never completes (watchdog case).
    task automatic run_xfer(input logic [NR-1:0] rq, input logic [NR*SW-1:0] sl,
                            input logic [NR*DW-1:0] dt, input int dly, input logic [DW-1:0] rx);
        int              w;
        int              s;
        logic [DW-1:0]   d;
        logic [NR-1:0]   w_oh;
        logic [NS-1:0]   ss_oh;
        logic [DW-1:0]   exp_data;
        logic            exp_err;
        bus.req       = rq;
        bus.req_slave = sl;
        bus.req_data  = dt;
        w    = model_pick(rq, ptr_m);
        s    = int'(sl[w*SW +: SW]);
        d    = dt[w*DW +: DW];
        w_oh = NR'(1) << w;
        @(negedge clk);
        if (s >= NS) begin
            exp_data = '0;
            exp_err  = 1'b1;
            check_eq("bad_done",  32'(bus.done), 32'(w_oh));
            check_eq("bad_err",   32'(bus.rsp_err), 32'(exp_err));
            check_eq("bad_data",  32'(bus.rsp_data), 32'(exp_data));
            check_eq("bad_start", 32'(bus.m_start), 32'd0);
            check_eq("bad_ss",    32'(bus.m_ss_sel), 32'd0);
        end else begin
            ss_oh = NS'(1) << s;
            check_eq("start",   32'(bus.m_start), 32'd1);
            check_eq("tx_data", 32'(bus.m_tx_data), 32'(d));
            check_eq("ss_sel",  32'(bus.m_ss_sel), 32'(ss_oh));
            bus.m_busy = 1'b1;
            if (dly < 0) begin
                exp_data = '0;
                exp_err  = 1'b1;
                repeat (TO - 1) @(negedge clk);
                check_eq("to_early", 32'(bus.done), 32'd0);
                @(negedge clk);
                bus.m_busy = 1'b0;
                check_eq("to_done", 32'(bus.done), 32'(w_oh));
                check_eq("to_err",  32'(bus.rsp_err), 32'd1);
                check_eq("to_data", 32'(bus.rsp_data), 32'd0);
            end else begin
                exp_data = rx;
                exp_err  = 1'b0;
                repeat (dly) @(negedge clk);
                check_eq("wait_start", 32'(bus.m_start), 32'd0);
                check_eq("wait_done",  32'(bus.done), 32'd0);
                check_eq("wait_ss",    32'(bus.m_ss_sel), 32'(ss_oh));
                bus.m_done    = 1'b1;
                bus.m_rx_data = rx;
                @(negedge clk);
                bus.m_done = 1'b0;
                bus.m_busy = 1'b0;
                check_eq("done",      32'(bus.done), 32'(w_oh));
                check_eq("rsp_data",  32'(bus.rsp_data), 32'(rx));
                check_eq("rsp_err",   32'(bus.rsp_err), 32'd0);
                check_eq("resp_ss",   32'(bus.m_ss_sel), 32'(ss_oh));
            end
        end
        check_eq("resp_active", 32'(bus.active), 32'd1);
        ptr_m = (w + 1) % NR;
        @(negedge clk);
        check_eq("idle_done",   32'(bus.done), 32'd0);
        check_eq("idle_ss",     32'(bus.m_ss_sel), 32'd0);
        check_eq("idle_active", 32'(bus.active), 32'd0);
        check_eq("hold_data",   32'(bus.rsp_data), 32'(exp_data));
        check_eq("hold_err",    32'(bus.rsp_err), 32'(exp_err));
    endtask

    initial begin
        logic [NR-1:0]    rq;
        logic [NR*SW-1:0] sl;
        logic [NR*DW-1:0] dt;
        rst_n         = 1'b0;
        bus.req       = '0;
        bus.req_slave = '0;
        bus.req_data  = '0;
        bus.m_busy    = 1'b0;
        bus.m_done    = 1'b0;
        bus.m_rx_data = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_done",   32'(bus.done), 32'd0);
        check_eq("rst_start",  32'(bus.m_start), 32'd0);
        check_eq("rst_ss",     32'(bus.m_ss_sel), 32'd0);
        check_eq("rst_active", 32'(bus.active), 32'd0);
        check_eq("rst_data",   32'(bus.rsp_data), 32'd0);
        rst_n = 1'b1;
        ptr_m = 0;

        // Fairness: everyone requesting from reset.
        for (int i = 0; i < 6; i++) begin
            dt = {$urandom, $urandom};
            run_xfer(4'hF, 8'h00, dt, int'($urandom_range(1, 5)), DW'($urandom));
        end

        run_xfer(4'b0010, 8'h00, {16'h0000, 16'h0000, 16'h1234, 16'h0000}, 40, 16'hBEEF);
        run_xfer(4'b0100, 8'b00_11_00_00, {4{16'hA5A5}}, 1, 16'h0000);

`ifdef SPI_ARB_TIMEOUT_EN
        run_xfer(4'b0001, 8'h00, {4{16'h5A5A}}, -1, 16'h0000);
        run_xfer(4'b0011, 8'h00, {16'h0, 16'h0, 16'h7777, 16'h6666}, 3, 16'hC0DE);
`endif

        for (int i = 0; i < 40; i++) begin
            rq = NR'($urandom_range(1, (1 << NR) - 1));
            sl = NR*SW'($urandom);
            dt = {$urandom, $urandom};
            run_xfer(rq, sl, dt, int'($urandom_range(1, 12)), DW'($urandom));
        end

        // Reset in the middle of a transfer.
        bus.req       = 4'b0010;
        bus.req_slave = 8'h00;
        bus.req_data  = {4{16'h3C3C}};
        @(negedge clk);
        check_eq("mid_start", 32'(bus.m_start), 32'd1);
        repeat (3) @(negedge clk);
        rst_n   = 1'b0;
        bus.req = '0;
        #1;
        check_eq("mid_rst_ss",     32'(bus.m_ss_sel), 32'd0);
        check_eq("mid_rst_active", 32'(bus.active), 32'd0);
        check_eq("mid_rst_tx",     32'(bus.m_tx_data), 32'd0);
        check_eq("mid_rst_data",   32'(bus.rsp_data), 32'd0);
        check_eq("mid_rst_err",    32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        check_eq("mid_rst_done",   32'(bus.done), 32'd0);
        rst_n = 1'b1;
        ptr_m = 0;
        run_xfer(4'b0101, 8'h00, {16'h0, 16'h2222, 16'h0, 16'h1111}, 4, 16'h4242);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
